// File: rtl/ray_pkg.sv
// Shared ray types, dispatcher state encoding and unit-count limits.
package ray_pkg;

    localparam int unsigned MAX_RAY_UNITS      = 16;
    localparam int unsigned RAY_POSITION_WIDTH = 16;
    localparam int unsigned STAT_WIDTH         = 32;

    typedef logic [2:0][RAY_POSITION_WIDTH-1:0] ray_vec_t;

    typedef enum logic {
        DISPATCH_EMPTY,
        DISPATCH_FULL
    } dispatch_state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (&value) ? value : value + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after pointer wins, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] pointer,
    output logic [NUM_REQ-1:0]   grant_c,
    output logic [PTR_WIDTH-1:0] index_c,
    output logic                 valid_c
);

    logic [31:0] pos;

    // Scan farthest-first so the closest requester after the pointer is the last writer.
    always_comb begin
        grant_c = '0;
        index_c = '0;
        valid_c = 1'b0;
        pos     = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            pos = 32'(pointer) + 32'(k);
            if (pos >= 32'(NUM_REQ)) begin
                pos = pos - 32'(NUM_REQ);
            end
            if (req[pos[PTR_WIDTH-1:0]]) begin
                grant_c = NUM_REQ'(1) << pos[PTR_WIDTH-1:0];
                index_c = pos[PTR_WIDTH-1:0];
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// One-entry ray buffer feeding NUM_UNITS ray units round-robin, with frame-drain detection.
// Optional per-unit issue and stall counters are built when RAY_DISPATCH_STATS_EN is defined.
module ray_dispatcher
    import ray_pkg::*;
#(
    parameter int unsigned POSITION_WIDTH = 16,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned PTR_WIDTH      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           rayValid,
    input  logic [2:0][POSITION_WIDTH-1:0] rayV,
    input  logic [ADDRESS_WIDTH-1:0]       rayAddress,
    output logic                           rayReady,
    input  logic                           genBusy,
    output logic [NUM_UNITS-1:0]           unitStart,
    output logic [2:0][POSITION_WIDTH-1:0] unitRayV,
    output logic [ADDRESS_WIDTH-1:0]       unitAddress,
    input  logic [NUM_UNITS-1:0]           unitBusy,
    output logic                           idle,
    output logic                           frameDone
`ifdef RAY_DISPATCH_STATS_EN
    ,
    output logic [NUM_UNITS-1:0][STAT_WIDTH-1:0] unitRayCount,
    output logic [STAT_WIDTH-1:0]                stallCycles
`endif
);

    if (NUM_UNITS < 1 || NUM_UNITS > MAX_RAY_UNITS) begin : g_bad_num_units
        $error("ray_dispatcher: NUM_UNITS out of range");
    end

    dispatch_state_t                state;
    logic [2:0][POSITION_WIDTH-1:0] buf_v;
    logic [ADDRESS_WIDTH-1:0]       buf_addr;
    logic [PTR_WIDTH-1:0]           pointer;
    logic                           armed;

    logic [NUM_UNITS-1:0] eligible_c;
    logic [NUM_UNITS-1:0] grant_c;
    logic [PTR_WIDTH-1:0] grant_idx_c;
    logic                 grant_valid_c;
    logic                 accept_c;
    logic                 idle_c;

    // A unit pulsed this cycle is still masked until its busy level appears.
    assign eligible_c = ~unitBusy & ~unitStart;
    assign accept_c   = rayValid && (state == DISPATCH_EMPTY);
    assign idle_c     = (state == DISPATCH_EMPTY) && (unitStart == '0) && (unitBusy == '0);

    rr_arbiter #(
        .NUM_REQ   (NUM_UNITS),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_arbiter (
        .req     (eligible_c),
        .pointer (pointer),
        .grant_c (grant_c),
        .index_c (grant_idx_c),
        .valid_c (grant_valid_c)
    );

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state       <= DISPATCH_EMPTY;
            rayReady    <= 1'b1;
            buf_v       <= '0;
            buf_addr    <= '0;
            unitStart   <= '0;
            unitRayV    <= '0;
            unitAddress <= '0;
            pointer     <= PTR_WIDTH'(NUM_UNITS - 1);
            idle        <= 1'b1;
            frameDone   <= 1'b0;
            armed       <= 1'b0;
        end else begin
            unitStart <= '0;
            frameDone <= 1'b0;
            idle      <= idle_c;
            case (state)
                DISPATCH_EMPTY: begin
                    if (accept_c) begin
                        state    <= DISPATCH_FULL;
                        rayReady <= 1'b0;
                        buf_v    <= rayV;
                        buf_addr <= rayAddress;
                        armed    <= 1'b1;
                    end
                end
                DISPATCH_FULL: begin
                    if (grant_valid_c) begin
                        state       <= DISPATCH_EMPTY;
                        rayReady    <= 1'b1;
                        unitStart   <= grant_c;
                        unitRayV    <= buf_v;
                        unitAddress <= buf_addr;
                        pointer     <= grant_idx_c;
                    end
                end
                default: begin
                    state    <= DISPATCH_EMPTY;
                    rayReady <= 1'b1;
                end
            endcase
            // Drain pulse lines up with idle rising; never coincides with an accept.
            if (armed && !genBusy && !rayValid && idle_c) begin
                frameDone <= 1'b1;
                armed     <= 1'b0;
            end
        end
    end

`ifdef RAY_DISPATCH_STATS_EN
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            unitRayCount <= '0;
            stallCycles  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_UNITS); i++) begin
                if (unitStart[i]) begin
                    unitRayCount[i] <= sat_inc(unitRayCount[i]);
                end
            end
            if ((state == DISPATCH_FULL) && !grant_valid_c) begin
                stallCycles <= sat_inc(stallCycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher: expected issues queued at accept, checked at unitStart.
module tb_ray_dispatcher;

    localparam int unsigned PW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned NU = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic                flush;
    logic                rayValid;
    logic [2:0][PW-1:0]  rayV;
    logic [AW-1:0]       rayAddress;
    logic                rayReady;
    logic                genBusy;
    logic [NU-1:0]       unitStart;
    logic [2:0][PW-1:0]  unitRayV;
    logic [AW-1:0]       unitAddress;
    logic [NU-1:0]       unitBusy;
    logic                idle;
    logic                frameDone;
`ifdef RAY_DISPATCH_STATS_EN
    logic [NU-1:0][31:0] unitRayCount;
    logic [31:0]         stallCycles;
`endif

    logic [NU-1:0] busy_force = '0;
    logic [NU-1:0] model_busy;
    int unsigned   dur [NU] = '{default: 0};
    int unsigned   cnt [NU] = '{default: 0};

    int cycle      = 0;
    int n_checks   = 0;
    int n_fail     = 0;
    int done_count = 0;
    int done_cycle = -1;
    int last_busy  = -1;
    bit mon_en     = 1'b0;

    typedef struct {
        int unsigned   unit;
        logic [AW-1:0] addr;
        logic [47:0]   v;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    ray_dispatcher #(
        .POSITION_WIDTH (PW),
        .ADDRESS_WIDTH  (AW),
        .NUM_UNITS      (NU)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .rayValid    (rayValid),
        .rayV        (rayV),
        .rayAddress  (rayAddress),
        .rayReady    (rayReady),
        .genBusy     (genBusy),
        .unitStart   (unitStart),
        .unitRayV    (unitRayV),
        .unitAddress (unitAddress),
        .unitBusy    (unitBusy),
        .idle        (idle),
        .frameDone   (frameDone)
`ifdef RAY_DISPATCH_STATS_EN
        ,
        .unitRayCount (unitRayCount),
        .stallCycles  (stallCycles)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Unit model: busy from the cycle after a start for dur[i] cycles.
    always @(posedge clock) begin
        for (int i = 0; i < int'(NU); i++) begin
            if (reset || flush)         cnt[i] <= 0;
            else if (unitStart[i])      cnt[i] <= dur[i];
            else if (cnt[i] != 0)       cnt[i] <= cnt[i] - 1;
        end
    end

    always_comb begin
        model_busy = '0;
        for (int i = 0; i < int'(NU); i++) model_busy[i] = (cnt[i] != 0);
    end

    assign unitBusy = busy_force | model_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [47:0] vec_of(input logic [AW-1:0] a);
        return {a[15:0], a[15:0] ^ 16'h5a5a, a[15:0] + 16'h0003};
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            if (unitStart !== '0) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_start", 64'(unitStart), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("start_unit",  64'(unitStart),   64'(1) << mon_e.unit);
                    check_eq("start_addr",  64'(unitAddress), 64'(mon_e.addr));
                    check_eq("start_rayv",  64'(unitRayV),    64'(mon_e.v));
                    check_eq("start_cycle", 64'(cycle),       64'(mon_e.cyc));
                end
            end
            if (frameDone === 1'b1) begin
                done_count++;
                done_cycle = cycle;
            end
            if (unitBusy !== '0) last_busy = cycle;
        end
    end

    task automatic send(input logic [AW-1:0] addr, input int unsigned unit, input int extra,
                        input bit expect_start, output int acc);
        int waited;
        waited     = 0;
        rayValid   = 1'b1;
        rayAddress = addr;
        rayV       = vec_of(addr);
        @(negedge clock);
        while (rayReady !== 1'b1 && waited < 60) begin
            @(negedge clock);
            waited++;
        end
        check_eq("accept_ready", 64'(rayReady), 64'(1));
        acc = cycle;
        if (expect_start) exp_q.push_back('{unit, addr, vec_of(addr), cycle + 2 + extra});
        @(posedge clock);
        #1;
        rayValid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clock);
            waited++;
        end
        #1;
        check_eq("drain_queue", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int done_before;
        reset      = 1'b1;
        flush      = 1'b0;
        genBusy    = 1'b1;
        rayValid   = 1'b1;
        rayAddress = 32'hdead;
        rayV       = vec_of(32'hdead);
        repeat (3) @(posedge clock);
        #1;
        reset    = 1'b0;
        rayValid = 1'b0;
        mon_en   = 1'b1;

        @(negedge clock);
        check_eq("rst_ready",     64'(rayReady),    64'(1));
        check_eq("rst_start",     64'(unitStart),   64'(0));
        check_eq("rst_addr",      64'(unitAddress), 64'(0));
        check_eq("rst_rayv",      64'(unitRayV),    64'(0));
        check_eq("rst_idle",      64'(idle),        64'(1));
        check_eq("rst_framedone", 64'(frameDone),   64'(0));
        @(posedge clock);
        #1;

        // Back-to-back rays, all units free: strict rotation starting at unit 0.
        for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), i % 4, 0, 1'b1, acc);
        drain();

        // All units busy: buffer holds for 20 cycles, then unit 2 frees up.
        busy_force = 4'b1111;
        send(32'h200, 2, 20, 1'b1, acc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_eq("stall_ready", 64'(rayReady), 64'(0));
            @(posedge clock);
            #1;
        end
        busy_force = 4'b1011;
        drain();
`ifdef RAY_DISPATCH_STATS_EN
        check_eq("stall_cycles", 64'(stallCycles), 64'(20));
        check_eq("unit2_count",  64'(unitRayCount[2]), 64'(3));
`endif
        busy_force = 4'b0000;

        // Walk pointer to 1, then a busy unit 2 is skipped and the next grant wraps.
        send(32'h300, 3, 0, 1'b1, acc);
        send(32'h301, 0, 0, 1'b1, acc);
        send(32'h302, 1, 0, 1'b1, acc);
        busy_force = 4'b0100;
        send(32'h303, 3, 0, 1'b1, acc);
        send(32'h304, 0, 0, 1'b1, acc);
        drain();
        busy_force = 4'b0000;

        // Flush with a grant about to issue: nothing starts, pointer back to last unit.
        send(32'h400, 0, 0, 1'b0, acc);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check_eq("flush_start", 64'(unitStart), 64'(0));
        check_eq("flush_ready", 64'(rayReady),  64'(1));
        check_eq("flush_idle",  64'(idle),      64'(1));
        genBusy = 1'b0;
        repeat (10) @(negedge clock);
        check_eq("flush_no_done", 64'(done_count), 64'(0));
        @(posedge clock);
        #1;
        genBusy = 1'b1;
        send(32'h401, 0, 0, 1'b1, acc);
        drain();

        // Frame drain: three rays with staggered unit latencies, one frameDone.
        dur[1] = 3;
        dur[2] = 12;
        dur[3] = 5;
        done_before = done_count;
        send(32'h500, 1, 0, 1'b1, acc);
        send(32'h501, 2, 0, 1'b1, acc);
        send(32'h502, 3, 0, 1'b1, acc);
        genBusy = 1'b0;
        repeat (40) @(negedge clock);
        check_eq("done_count", 64'(done_count - done_before), 64'(1));
        check_eq("done_cycle", 64'(done_cycle), 64'(last_busy + 2));
        check_eq("done_idle",  64'(idle),       64'(1));
        check_eq("done_pulse", 64'(frameDone),  64'(0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
